// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the memory-bus arbiter:
//   - FSM state encodings: ARB_IDLE, ARB_ACCESS, ARB_DONE.
//   - Grant encodings: GNT_IF, GNT_MEM.
//   - WriteEnable / WriteDisable and ZeroData constants.
//   - Wait-timer width.
//   - arb_pick(), the grant decision shared by fixed-priority and
//     round-robin builds.
//   Optional feature macro used by the arbiter: MEM_ARB_ROUND_ROBIN_EN.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } arb_gnt_e;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  // Wide enough for any data bus up to 64 bits; users slice it to DATA_W.
  localparam int unsigned MaxDataW = 64;
  localparam logic [MaxDataW-1:0] ZeroData = '0;

  localparam int unsigned TimerW = 4;

  // An uncontended request always wins.
  // On contention MEM wins, unless prefer_if is set
  // (round-robin build after a MEM grant).
  function automatic arb_gnt_e arb_pick(input logic if_req,
                                        input logic mem_req,
                                        input logic prefer_if);
    arb_gnt_e gnt;
    if (if_req && (!mem_req || prefer_if)) gnt = GNT_IF;
    else                                   gnt = GNT_MEM;
    return gnt;
  endfunction

endpackage

// File: rtl/mem_arbiter_wait_timer.sv
// arb_wait_timer
//   Loadable 4-bit down-counter that measures the length of a bus access.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     start     : load load_val (takes priority over counting)
//     load_val  : value loaded on start (number of cycles minus one)
//     done      : count has reached zero; the cycle in which done is seen
//                 while counting is the final cycle of the interval
module arb_wait_timer
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TimerW-1:0] load_val,
  output logic              done
);

  logic [TimerW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start)               count_d = load_val;
    else if (count_q != '0)  count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one fixed-latency single-port memory bus between the instruction
//   fetch port (IF, read only) and the load/store port (MEM).
//   Each access has three phases:
//     IDLE   : arbitrates and latches the winning request.
//     ACCESS : drives the bus for WAIT_CYCLES cycles.
//     DONE   : pulses the winner's ack with its read data for one cycle.
//   Ports:
//     clk, rst                     : clock, synchronous active-high reset
//     if_req/if_addr               : IF read request
//     if_rdata/if_ack              : IF read data and completion pulse
//     mem_req/we/addr/wdata/be     : MEM request
//     mem_rdata/mem_ack            : MEM read data (0 for writes) and
//                                    completion pulse
//     bus_ce/we/addr/wdata/be      : memory bus request
//                                    (bus_be all ones for reads)
//     bus_rdata                    : memory read data, valid in the last
//                                    ACCESS cycle
//     stall_if/stall_mem           : req & ~ack, for the pipeline control
//   Configuration macro:
//     MEM_ARB_ROUND_ROBIN_EN : alternate winners on contention instead of
//                              fixed MEM-over-IF priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_ack,
  output logic                bus_ce,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                stall_if,
  output logic                stall_mem
);

  localparam int unsigned BE_W = DATA_W / 8;
  // The timer counts down from WAIT_CYCLES-1 to 0 during ACCESS.
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(WAIT_CYCLES - 1);

  arb_state_e        state_q, state_d;
  arb_gnt_e          gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              mem_ack_q, mem_ack_d;

  logic              timer_start;
  logic              timer_done;
  logic              prefer_if;
  arb_gnt_e          gnt_pick;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_gnt_e last_grant_q, last_grant_d;

  // After a MEM grant, IF wins the next contention, and vice versa.
  assign prefer_if = (last_grant_q == GNT_MEM);

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == ARB_IDLE && (if_req || mem_req)) last_grant_d = gnt_pick;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= GNT_IF;
    else     last_grant_q <= last_grant_d;
  end
`else
  assign prefer_if = 1'b0;
`endif

  assign gnt_pick = arb_pick(if_req, mem_req, prefer_if);

  arb_wait_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (timer_start),
    .load_val (TimerLoad),
    .done     (timer_done)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rdata_d     = rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    timer_start = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (if_req || mem_req) begin
          state_d     = ARB_ACCESS;
          timer_start = 1'b1;
          gnt_d       = gnt_pick;
          // Latch the whole request, so that input changes during the
          // access cannot disturb the bus.
          if (gnt_pick == GNT_MEM) begin
            we_d    = mem_we;
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            be_d    = mem_we ? mem_be : {BE_W{1'b1}};
          end else begin
            we_d    = WriteDisable;
            addr_d  = if_addr;
            wdata_d = ZeroData[DATA_W-1:0];
            be_d    = {BE_W{1'b1}};
          end
        end
      end

      ARB_ACCESS: begin
        if (timer_done) begin
          state_d   = ARB_DONE;
          // Writes return zero data, so capture nothing for them.
          rdata_d   = (we_q == WriteEnable) ? ZeroData[DATA_W-1:0] : bus_rdata;
          if_ack_d  = (gnt_q == GNT_IF);
          mem_ack_d = (gnt_q == GNT_MEM);
        end
      end

      ARB_DONE: state_d = ARB_IDLE;

      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= GNT_IF;
      we_q      <= WriteDisable;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rdata_q   <= rdata_d;
      if_ack_q  <= if_ack_d;
      mem_ack_q <= mem_ack_d;
    end
  end

  // Bus fields are held at zero outside ACCESS, so the SRAM side sees a
  // quiet bus between accesses.
  assign bus_ce    = (state_q == ARB_ACCESS);
  assign bus_we    = bus_ce && (we_q == WriteEnable);
  assign bus_addr  = bus_ce ? addr_q  : '0;
  assign bus_wdata = bus_ce ? wdata_q : '0;
  assign bus_be    = bus_ce ? be_q    : '0;

  // Only the acked port sees the captured data; the other port reads 0.
  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign if_rdata  = if_ack_q  ? rdata_q : ZeroData[DATA_W-1:0];
  assign mem_rdata = mem_ack_q ? rdata_q : ZeroData[DATA_W-1:0];

  assign stall_if  = if_req  & ~if_ack_q;
  assign stall_mem = mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter (WAIT_CYCLES = 2).
//   Every cycle the DUT outputs are compared with a transaction-level
//   reference model. The model tracks the access in flight by its start
//   cycle and derives bus, ack and stall timing arithmetically from that
//   start cycle. Directed scenarios come first, followed by randomized
//   requesters. Honours MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_ce;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        stall_if;
  logic        stall_mem;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .bus_ce    (bus_ce),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_rdata (bus_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // act    : an access is in flight
  // t0     : cycle in which it was granted (the IDLE cycle)
  // bus    : t0+1 .. t0+W
  // ack    : t0+W+1
  bit          act = 1'b0;
  int          t0 = 0;
  bit          t_mem, t_we, last_mem = 1'b0;
  logic [31:0] t_addr, t_wdata, t_rd;
  logic [3:0]  t_be;
  bit          if_ack_seen = 1'b0, mem_ack_seen = 1'b0;

  always @(negedge clk) begin
    bit exp_ce, exp_done, exp_we, prefer_if;
    exp_ce   = act && (cyc > t0) && (cyc <= t0 + W);
    exp_done = act && (cyc == t0 + W + 1);
    exp_we   = exp_ce && t_mem && t_we;

    check_eq("bus_ce", bus_ce, exp_ce);
    check_eq("bus_we", bus_we, exp_we);
    check_eq("if_ack", if_ack, exp_done && !t_mem);
    check_eq("mem_ack", mem_ack, exp_done && t_mem);
    check_eq("stall_if", stall_if, if_req && !(exp_done && !t_mem));
    check_eq("stall_mem", stall_mem, mem_req && !(exp_done && t_mem));
    if (exp_ce) begin
      check_eq("bus_addr", bus_addr, t_addr);
      check_eq("bus_be", bus_be, (t_mem && t_we) ? t_be : 4'hF);
    end
    if (exp_we) check_eq("bus_wdata", bus_wdata, t_wdata);
    if (exp_done) begin
      check_eq("if_rdata", if_rdata, t_mem ? 32'h0 : t_rd);
      check_eq("mem_rdata", mem_rdata, (t_mem && !t_we) ? t_rd : 32'h0);
      $display("txn cycle=%0d port=%s %s addr=%08h data=%08h",
               cyc, t_mem ? "MEM" : "IF", t_we ? "wr" : "rd", t_addr,
               t_we ? t_wdata : t_rd);
    end
    if_ack_seen  <= if_ack;
    mem_ack_seen <= mem_ack;

    // advance the model to the next cycle
    if (act && cyc == t0 + W) t_rd = bus_rdata;
    if (rst) begin
      act      = 1'b0;
      last_mem = 1'b0;
    end else if (exp_done) begin
      act = 1'b0;
    end else if (!act && (if_req || mem_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      prefer_if = last_mem;
`else
      prefer_if = 1'b0;
`endif
      t_mem    = mem_req && !(if_req && prefer_if);
      last_mem = t_mem;
      act      = 1'b1;
      t0       = cyc;
      t_we     = t_mem && mem_we;
      t_addr   = t_mem ? mem_addr : if_addr;
      t_wdata  = mem_wdata;
      t_be     = mem_be;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic wait_ack(input bit is_mem);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = is_mem ? mem_ack : if_ack;
    end
    if (!seen) check_eq(is_mem ? "mem_ack_timeout" : "if_ack_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_be = '0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_bus_ce", bus_ce, 0);
    check_eq("rst_if_ack", if_ack, 0);
    check_eq("rst_mem_ack", mem_ack, 0);
    check_eq("rst_bus_addr", bus_addr, 0);
    @(posedge clk); #1;

    // IF read
    if_req = 1'b1; if_addr = 32'h100; bus_rdata = 32'hDEADBEEF;
    wait_ack(1'b0);
    if_req = 1'b0;

    // MEM write with partial byte enables
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2000;
    mem_wdata = 32'h12345678; mem_be = 4'b0011;
    wait_ack(1'b1);
    mem_req = 1'b0;

    // contention: MEM first, IF in the following access
    if_req = 1'b1; if_addr = 32'h200; mem_req = 1'b1; mem_we = 1'b0;
    mem_addr = 32'h3000; bus_rdata = 32'hCAFEF00D;
    wait_ack(1'b1);
    mem_req = 1'b0;
    wait_ack(1'b0);
    if_req = 1'b0;

    // both held continuously: order depends on arbitration mode
    if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0;
    repeat (4 * (W + 2)) @(posedge clk);
    #1 if_req = 1'b0; mem_req = 1'b0;
    repeat (W + 3) @(posedge clk);
    #1;

    // reset in the first ACCESS cycle of a MEM read aborts it
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h4000;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; mem_req = 1'b0;
    if_req = 1'b1; if_addr = 32'h300;
    wait_ack(1'b0);

    // IF held across its ack with a new address
    if_addr = 32'h100;
    wait_ack(1'b0);
    if_addr = 32'h104;
    wait_ack(1'b0);
    if_req = 1'b0;

    // randomized requesters
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 199) == 0);
      if (if_req) begin
        if (if_ack_seen) if_req = 1'($urandom_range(0, 1));
        else if ($urandom_range(0, 24) == 0) if_req = 1'b0;
      end else begin
        if_req = ($urandom_range(0, 2) == 0);
      end
      if (mem_req) begin
        if (mem_ack_seen) mem_req = 1'($urandom_range(0, 1));
        else if ($urandom_range(0, 24) == 0) mem_req = 1'b0;
      end else begin
        mem_req = ($urandom_range(0, 2) == 0);
      end
      if_addr   = $urandom;
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      mem_be    = 4'($urandom_range(0, 15));
      mem_we    = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
    end

    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b0; mem_req = 1'b0;
    repeat (W + 4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
